bus_timer_slave: RTL and testbench

- Memory-mapped responder on the CPU data bus: the target end of the read/write/byteenable/waitrequest/response interface driven by the RISC-V core wrapper.
- Implements a 32-bit down-counting timer with auto-reload and returns an interrupt line to the core's irq input.
- Inserts programmable wait states and reports OKAY, slave-error and decode-error responses.

---
 rtl/bus_timer_slave.sv | 164 ++++++++++++++++
 tb/tb_bus_timer_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_slave.sv
// Memory-mapped 32-bit down-counting timer with auto-reload, on a read/write/waitrequest bus.
// Programmable wait states; returns OKAY / SLVERR / DECERR and a level interrupt.
`timescale 1ns/1ps
module bus_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_writedata,
    input  logic [3:0]  bus_byteenable,
    output logic [31:0] bus_readdata,
    output logic [1:0]  bus_response,
    output logic        bus_waitrequest,
    output logic        irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [3:0] LAT_LAST    = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [2:0]  ctrl;
    logic        expired;
    logic [31:0] load;
    logic [31:0] count;

    logic [31:0] dec_addr;
    logic        dec_write;
    logic        in_window;
    logic        aligned;
    logic [1:0]  reg_sel;
    logic [1:0]  resp_next;
    logic [31:0] rdata_next;
    logic        commit;
    logic        timer_set;
    logic [31:0] load_merged;

    // With LATENCY=0 the ACK is entered straight from IDLE, so decode the live request there.
    assign dec_addr  = (state == IDLE) ? bus_addr  : lat_addr;
    assign dec_write = (state == IDLE) ? bus_write : lat_write;
    assign in_window = (dec_addr[31:4] == BASE_ADDR[31:4]);
    assign aligned   = (dec_addr[1:0] == 2'b00);
    assign reg_sel   = dec_addr[3:2];

    assign commit    = (state == ACK) && lat_write && in_window && aligned;
    assign timer_set = ctrl[0] && (count == 32'd1);

    always_comb begin
        resp_next  = RESP_OKAY;
        rdata_next = '0;
        if (!in_window) begin
            resp_next = RESP_DECERR;
        end else if (!aligned) begin
            resp_next = RESP_SLVERR;
        end else if (dec_write) begin
            if (reg_sel == 2'd3) resp_next = RESP_SLVERR;
        end else begin
            case (reg_sel)
                2'd0:    rdata_next = {29'd0, ctrl};
                2'd1:    rdata_next = {31'd0, expired};
                2'd2:    rdata_next = load;
                default: rdata_next = count;
            endcase
        end
    end

    always_comb begin
        load_merged = load;
        for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) load_merged[8*i +: 8] = lat_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus_read || bus_write) state_next = (LATENCY == 0) ? ACK : WAIT;
            WAIT: if (wait_cnt == LAT_LAST) state_next = ACK;
            ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt        <= '0;
            lat_write       <= 1'b0;
            bus_waitrequest <= 1'b1;
            bus_readdata    <= '0;
            bus_response    <= RESP_OKAY;
        end else begin
            bus_waitrequest <= (state_next != ACK);
            if (state == IDLE && (bus_read || bus_write)) begin
                lat_write <= bus_write;
                wait_cnt  <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (state_next == ACK && state != ACK) begin
                bus_readdata <= rdata_next;
                bus_response <= resp_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && (bus_read || bus_write)) begin
            lat_addr  <= bus_addr;
            lat_wdata <= bus_writedata;
            lat_be    <= bus_byteenable;
        end
    end

    // Timer and register file; a bus LOAD write overrides the timer's COUNT update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            expired <= 1'b0;
            load    <= '0;
            count   <= '0;
            irq     <= 1'b0;
        end else begin
            irq <= expired & ctrl[1];
            if (ctrl[0]) begin
                if (count > 32'd1)       count <= count - 32'd1;
                else if (count == 32'd1) count <= '0;
                else if (ctrl[2])        count <= load;
            end
            if (timer_set)
                expired <= 1'b1;
            else if (commit && reg_sel == 2'd1 && lat_be[0] && lat_wdata[0])
                expired <= 1'b0;
            if (commit) begin
                case (reg_sel)
                    2'd0: if (lat_be[0]) ctrl <= lat_wdata[2:0];
                    2'd2: begin
                        load  <= load_merged;
                        count <= load_merged;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave: bus timing, timer/irq behaviour, byte lanes, errors, reset.
`timescale 1ns/1ps
module tb_bus_timer_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_readdata;
    logic [1:0]  bus_response;
    logic        bus_waitrequest;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd;
    logic [1:0]  last_resp;
    int          last_lat;

    always #5 clk = ~clk;

    bus_timer_slave #(.BASE_ADDR(BASE), .LATENCY(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_addr       (bus_addr),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_writedata  (bus_writedata),
        .bus_byteenable (bus_byteenable),
        .bus_readdata   (bus_readdata),
        .bus_response   (bus_response),
        .bus_waitrequest(bus_waitrequest),
        .irq            (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; holds the request until acknowledged, returns just after the
    // posedge that ends the ACK cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        int lat;
        bus_addr       = addr;
        bus_writedata  = wdata;
        bus_byteenable = be;
        bus_write      = wr;
        bus_read       = !wr;
        lat = 0;
        @(negedge clk);
        while (bus_waitrequest && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("xfer_ack", 32'(bus_waitrequest), 32'd0);
        last_rd   = bus_readdata;
        last_resp = bus_response;
        last_lat  = lat;
        @(posedge clk);
        #1;
        bus_read  = 1'b0;
        bus_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bus_addr = '0; bus_read = 1'b0; bus_write = 1'b0;
        bus_writedata = '0; bus_byteenable = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_waitreq", 32'(bus_waitrequest), 32'd1);
        chk("rst_rdata", bus_readdata, 32'd0);
        chk("rst_resp", 32'(bus_response), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;

        // Test 1: read CTRL
        xfer(1'b0, BASE, 32'd0, 4'h0);
        chk("t1_latency", 32'(last_lat), 32'd2);
        chk("t1_rdata", last_rd, 32'd0);
        chk("t1_resp", 32'(last_resp), 32'd0);
        @(negedge clk);
        chk("t1_waitreq_back", 32'(bus_waitrequest), 32'd1);
        @(posedge clk); #1;

        // Test 2: one-shot countdown and irq
        xfer(1'b1, BASE + 32'h8, 32'd5, 4'hF);
        chk("t2_load_resp", 32'(last_resp), 32'd0);
        chk("t2_load_wr_rdata", last_rd, 32'd0);
        xfer(1'b1, BASE, 32'd3, 4'hF);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t2_irq_c5", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t2_irq_c6", 32'(irq), 32'd1);
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'h0);
        chk("t2_status", last_rd, 32'd1);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'h0);
        chk("t2_count_zero", last_rd, 32'd0);
        xfer(1'b1, BASE + 32'h8, 32'd100, 4'hF);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'h0);
        chk("t2_count_a", last_rd, 32'd99);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'h0);
        chk("t2_count_b", last_rd, 32'd96);
        xfer(1'b1, BASE + 32'h4, 32'd1, 4'h1);
        @(negedge clk);
        chk("t2_irq_w1c_delay", 32'(irq), 32'd1);
        @(negedge clk);
        chk("t2_irq_cleared", 32'(irq), 32'd0);
        @(posedge clk); #1;
        xfer(1'b1, BASE, 32'd0, 4'hF);

        // Test 3: auto-reload, W1C colliding with an expiry
        xfer(1'b1, BASE + 32'h8, 32'd3, 4'hF);
        xfer(1'b1, BASE, 32'd7, 4'hF);
        xfer(1'b1, BASE + 32'h4, 32'd1, 4'h1);
        @(negedge clk);
        chk("t3_irq_c3", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t3_set_wins", 32'(irq), 32'd1);
        @(posedge clk); #1;
        xfer(1'b1, BASE + 32'h4, 32'd1, 4'h1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_irq_c9", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_irq_c11", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t3_irq_reexpire", 32'(irq), 32'd1);
        @(posedge clk); #1;
        xfer(1'b1, BASE, 32'd0, 4'hF);
        xfer(1'b1, BASE + 32'h4, 32'd1, 4'h1);

        // Test 4: byte lanes
        xfer(1'b1, BASE, 32'hFFFF_FFFF, 4'b0010);
        chk("t4_ctrl_wr_resp", 32'(last_resp), 32'd0);
        xfer(1'b0, BASE, 32'd0, 4'h0);
        chk("t4_ctrl_lane", last_rd, 32'd0);
        xfer(1'b1, BASE + 32'h8, 32'd0, 4'hF);
        xfer(1'b1, BASE + 32'h8, 32'hAABB_CCDD, 4'b0101);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'h0);
        chk("t4_load_lanes", last_rd, 32'h00BB_00DD);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'h0);
        chk("t4_count_copy", last_rd, 32'h00BB_00DD);

        // Test 5: error paths
        xfer(1'b0, BASE + 32'h20, 32'd0, 4'h0);
        chk("t5_decerr_resp", 32'(last_resp), 32'd3);
        chk("t5_decerr_rdata", last_rd, 32'd0);
        xfer(1'b1, BASE + 32'h6, 32'hFFFF_FFFF, 4'hF);
        chk("t5_misalign_resp", 32'(last_resp), 32'd2);
        xfer(1'b1, BASE + 32'hC, 32'h0000_1234, 4'hF);
        chk("t5_count_wr_resp", 32'(last_resp), 32'd2);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'h0);
        chk("t5_count_kept", last_rd, 32'h00BB_00DD);
        chk("t5_okay_after_err", 32'(last_resp), 32'd0);
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'h0);
        chk("t5_status_clear", last_rd, 32'd0);

        // Test 6: reset during WAIT of a LOAD write
        bus_addr = BASE + 32'h8; bus_writedata = 32'h55; bus_byteenable = 4'hF; bus_write = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_wait_waitreq", 32'(bus_waitrequest), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_write = 1'b0;
        @(negedge clk);
        chk("t6_rst_waitreq", 32'(bus_waitrequest), 32'd1);
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'h0);
        chk("t6_load_zero", last_rd, 32'd0);
        chk("t6_latency", 32'(last_lat), 32'd2);
        xfer(1'b1, BASE + 32'h8, 32'h0000_1234, 4'hF);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'h0);
        chk("t6_load_after", last_rd, 32'h0000_1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
